// File: rtl/chacha_pkg.sv
// Shared types and constants for the iterative ChaCha20 block generator.
// The quarter-round index helper maps (lane, slot) to a state word for column or diagonal rounds.
package chacha_pkg;

  localparam int CHACHA_ROUNDS = 20;

  // "expand 32-byte k", word 0 in the low slice
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef logic [15:0][31:0] chacha_state_t;
  typedef logic [3:0][31:0]  qr_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } chacha_fsm_t;

  // Word index = 4*slot + column; diagonal rounds shift the column by the slot number (mod 4).
  function automatic logic [3:0] qr_index(input logic [1:0] lane, input logic [1:0] slot,
                                          input logic diag);
    logic [1:0] col;
    if (diag) begin
      col = lane + slot;
    end else begin
      col = lane;
    end
    return {slot, col};
  endfunction

endpackage

// File: rtl/chacha_block_gen_quarter_round.sv
// Purely combinational ChaCha quarter-round (RFC 8439): add, xor, rotate by 16/12/8/7.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  qr_vec_t x_in,
  output qr_vec_t x_out
);

  logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;
  logic [31:0] d1_x, b1_x, d2_x, b2_x;

  assign a1   = x_in[0] + x_in[1];
  assign d1_x = x_in[3] ^ a1;
  assign d1   = {d1_x[15:0], d1_x[31:16]};
  assign c1   = x_in[2] + d1;
  assign b1_x = x_in[1] ^ c1;
  assign b1   = {b1_x[19:0], b1_x[31:20]};

  assign a2   = a1 + b1;
  assign d2_x = d1 ^ a2;
  assign d2   = {d2_x[23:0], d2_x[31:24]};
  assign c2   = c1 + d2;
  assign b2_x = b1 ^ c2;
  assign b2   = {b2_x[24:0], b2_x[31:25]};

  assign x_out = {d2, c2, b2, a2};

endmodule

// File: rtl/chacha_block_gen.sv
// Iterative ChaCha20 block function: one round per cycle, keystream on valid/ready,
// and a registered ctr_inc pulse on handshake to advance the upstream block counter.
module chacha_block_gen
  import chacha_pkg::*;
#(
  parameter int ROUNDS = CHACHA_ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] ks_data,
  output logic         ctr_inc
);

  chacha_fsm_t   state, next_state;
  chacha_state_t init_reg, work_reg;
  chacha_state_t init_state, round_state, sum_state;
  logic [7:0]    rnd;
  logic          load, do_round, do_final, handshake;
  qr_vec_t       qr_in  [4];
  qr_vec_t       qr_out [4];

  // Assemble the initial state from constants, key, counter and nonce.
  always_comb begin
    init_state = '0;
    for (int i = 0; i < 4; i++) init_state[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) init_state[4 + i] = key[32*i +: 32];
    init_state[12] = counter;
    for (int i = 0; i < 3; i++) init_state[13 + i] = nonce[32*i +: 32];
  end

  // Gather quarter-round operands; rnd[0] selects column (0) or diagonal (1) mapping.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 4; l++) begin
        qr_in[j][l] = work_reg[qr_index(2'(j), 2'(l), rnd[0])];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarter_round u_qr (
      .x_in  (qr_in[g]),
      .x_out (qr_out[g])
    );
  end

  // Scatter quarter-round results back to their state positions.
  always_comb begin
    round_state = work_reg;
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 4; l++) begin
        round_state[qr_index(2'(j), 2'(l), rnd[0])] = qr_out[j][l];
      end
    end
  end

  // Final feed-forward: wordwise add, no carry between words.
  always_comb begin
    for (int i = 0; i < 16; i++) sum_state[i] = work_reg[i] + init_reg[i];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    do_round   = 1'b0;
    do_final   = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ROUND;
        end else begin
          next_state = IDLE;
        end
      end
      ROUND: begin
        do_round = 1'b1;
        if (rnd == 8'(ROUNDS - 1)) begin
          next_state = FINAL;
        end else begin
          next_state = ROUND;
        end
      end
      FINAL: begin
        do_final   = 1'b1;
        next_state = OUT;
      end
      OUT: begin
        if (ks_ready) begin
          handshake  = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = OUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Working/initial state, round counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_reg <= '0;
      work_reg <= '0;
      rnd      <= 8'd0;
      busy     <= 1'b0;
      ks_valid <= 1'b0;
      ks_data  <= 512'd0;
      ctr_inc  <= 1'b0;
    end else begin
      busy    <= (next_state != IDLE);
      ctr_inc <= handshake;
      if (load) begin
        init_reg <= init_state;
        work_reg <= init_state;
        rnd      <= 8'd0;
      end else if (do_round) begin
        work_reg <= round_state;
        rnd      <= rnd + 8'd1;
      end
      if (do_final) begin
        ks_data  <= sum_state;
        ks_valid <= 1'b1;
      end else if (handshake) begin
        ks_valid <= 1'b0;
      end
    end
  end

endmodule
